// File: rtl/rect_fill_engine.sv
// Rectangle fill engine: one clipped pixel write per cycle, row-major, into a WIDTHxHEIGHT frame buffer.
// Optional outline-only mode is compiled in with `define RECT_OUTLINE_EN.
module rect_fill_engine #(
    parameter int WIDTH        = 160,
    parameter int HEIGHT       = 120,
    parameter int BITSPERPIXEL = 8
) (
    input  logic                    clk_in,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [7:0]              x0,
    input  logic [7:0]              y0,
    input  logic [7:0]              w,
    input  logic [7:0]              h,
    input  logic [BITSPERPIXEL-1:0] color_in,
`ifdef RECT_OUTLINE_EN
    input  logic                    outline,
`endif
    output logic                    busy,
    output logic                    done,
    output logic [7:0]              x,
    output logic [7:0]              y,
    output logic [BITSPERPIXEL-1:0] color,
    output logic                    write
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [8:0] W9 = 9'(WIDTH);
    localparam logic [8:0] H9 = 9'(HEIGHT);

    logic [1:0] state;
    logic [7:0] x0_r;
    logic [8:0] xe_r;
    logic [8:0] ye_r;

    logic [8:0] sum_x, sum_y, xe_c, ye_c, x_inc, y_inc;
    logic       empty_c, wrap, last;
    logic [7:0] nx, ny;
    logic       pix_write;

`ifdef RECT_OUTLINE_EN
    logic [7:0] y0_r;
    logic [8:0] xl_r;
    logic [8:0] yl_r;
    logic       outline_r;
`endif

    // Command decode: end bounds are exclusive and clipped to the screen in 9 bits.
    always_comb begin
        sum_x   = {1'b0, x0} + {1'b0, w};
        sum_y   = {1'b0, y0} + {1'b0, h};
        xe_c    = (sum_x > W9) ? W9 : sum_x;
        ye_c    = (sum_y > H9) ? H9 : sum_y;
        empty_c = (w == 8'd0) || (h == 8'd0) || ({1'b0, x0} >= W9) || ({1'b0, y0} >= H9);
    end

    // Cursor advance from the pixel currently on x/y.
    always_comb begin
        x_inc = {1'b0, x} + 9'd1;
        y_inc = {1'b0, y} + 9'd1;
        wrap  = (x_inc == xe_r);
        last  = wrap && (y_inc == ye_r);
        nx    = wrap ? x0_r : x_inc[7:0];
        ny    = wrap ? y_inc[7:0] : y;
`ifdef RECT_OUTLINE_EN
        pix_write = !outline_r
                 || ({1'b0, nx} == {1'b0, x0_r}) || ({1'b0, nx} == xl_r)
                 || ({1'b0, ny} == {1'b0, y0_r}) || ({1'b0, ny} == yl_r);
`else
        pix_write = 1'b1;
`endif
    end

    // NOTE: reset is synchronous, so it sits inside the clocked block and wins over every other branch.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            write <= 1'b0;
            x     <= '0;
            y     <= '0;
            color <= '0;
            x0_r  <= '0;
            xe_r  <= '0;
            ye_r  <= '0;
`ifdef RECT_OUTLINE_EN
            y0_r      <= '0;
            xl_r      <= '0;
            yl_r      <= '0;
            outline_r <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        x0_r <= x0;
                        xe_r <= xe_c;
                        ye_r <= ye_c;
`ifdef RECT_OUTLINE_EN
                        y0_r      <= y0;
                        xl_r      <= sum_x - 9'd1;
                        yl_r      <= sum_y - 9'd1;
                        outline_r <= outline;
`endif
                        busy <= 1'b1;
                        if (empty_c) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            // The origin is always on the border, so the first cycle always writes.
                            state <= S_FILL;
                            x     <= x0;
                            y     <= y0;
                            color <= color_in;
                            write <= 1'b1;
                        end
                    end
                end
                S_FILL: begin
                    if (last) begin
                        state <= S_DONE;
                        write <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        x     <= nx;
                        y     <= ny;
                        write <= pix_write;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    write <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rect_fill_engine.sv
// Self-checking bench for rect_fill_engine: directed plan cases plus randomized commands against a
// pixel-list reference model. Outline cases compile in with `define RECT_OUTLINE_EN.
module tb_rect_fill_engine;

    localparam int WIDTH  = 160;
    localparam int HEIGHT = 120;
    localparam int BPP    = 8;

    logic           clk_in;
    logic           rst_n;
    logic           start;
    logic [7:0]     x0, y0, w, h;
    logic [BPP-1:0] color_in;
`ifdef RECT_OUTLINE_EN
    logic           outline;
`endif
    logic           busy, done, write;
    logic [7:0]     x, y;
    logic [BPP-1:0] color;

    rect_fill_engine #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .BITSPERPIXEL(BPP)) dut (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .start    (start),
        .x0       (x0),
        .y0       (y0),
        .w        (w),
        .h        (h),
        .color_in (color_in),
`ifdef RECT_OUTLINE_EN
        .outline  (outline),
`endif
        .busy     (busy),
        .done     (done),
        .x        (x),
        .y        (y),
        .color    (color),
        .write    (write)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct {
        int px;
        int py;
        int pc;
    } pixel_t;

    pixel_t exp_q[$];
    int     n_checks = 0;
    int     n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
    endtask

    // Reference: visit every pixel of the unclipped rectangle in row-major order, keep the on-screen
    // ones (the sweep), and of those the ones that are written (all, or only border pixels).
    task automatic build_expected(input int rx, input int ry, input int rw, input int rh,
                                  input int rc, input bit ol, output int sweep);
        exp_q.delete();
        sweep = 0;
        for (int yy = ry; yy < ry + rh; yy++) begin
            for (int xx = rx; xx < rx + rw; xx++) begin
                if (xx < WIDTH && yy < HEIGHT) begin
                    sweep++;
                    if (!ol || xx == rx || xx == rx + rw - 1 || yy == ry || yy == ry + rh - 1)
                        exp_q.push_back('{px: xx, py: yy, pc: rc});
                end
            end
        end
    endtask

    // Issues one command and checks every cycle up to and including the done pulse.
    // poke=1 pulses start with another colour during cycle 2, which must be ignored.
    task automatic run_cmd(input int rx, input int ry, input int rw, input int rh,
                           input int rc, input bit ol, input bit poke);
        int  sweep;
        bit  got_done;
        pixel_t e;
        build_expected(rx, ry, rw, rh, rc, ol, sweep);
        @(negedge clk_in);
        check("idle_busy", busy, 0);
        start    = 1'b1;
        x0       = 8'(rx);
        y0       = 8'(ry);
        w        = 8'(rw);
        h        = 8'(rh);
        color_in = BPP'(rc);
`ifdef RECT_OUTLINE_EN
        outline  = ol;
`endif
        @(posedge clk_in);
        #1 start = 1'b0;
        got_done = 1'b0;
        for (int c = 1; c <= sweep + 10 && !got_done; c++) begin
            @(negedge clk_in);
            check("busy", busy, 1);
            if (write) begin
                if (exp_q.size() == 0) begin
                    check("extra_write", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_x", x, e.px);
                    check("wr_y", y, e.py);
                    check("wr_color", color, e.pc);
                end
            end
            if (done) begin
                got_done = 1'b1;
                check("done_cycle", c, sweep + 1);
                check("done_write", write, 0);
            end
            start    = poke && (c == 2);
            color_in = BPP'(~rc);
        end
        start = 1'b0;
        if (!got_done) check("done_timeout", 0, 1);
        check("missed_writes", exp_q.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_write"}, write, 0);
        check({tag, "_x"}, x, 0);
        check({tag, "_y"}, y, 0);
        check({tag, "_color"}, color, 0);
    endtask

    // Full-screen clear aborted by reset at cycle 50.
    task automatic reset_mid_command();
        @(negedge clk_in);
        start = 1'b1; x0 = 8'd0; y0 = 8'd0; w = 8'd160; h = 8'd120; color_in = 8'h5A;
`ifdef RECT_OUTLINE_EN
        outline = 1'b0;
`endif
        @(posedge clk_in);
        #1 start = 1'b0;
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk_in);
            if (c == 1 || c == 50) begin
                check("clr_write", write, 1);
                check("clr_x", x, (c - 1) % WIDTH);
            end
        end
        rst_n = 1'b0;
        @(negedge clk_in);
        check_all_zero("mid_rst");
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_in);
            check("post_rst_write", write, 0);
            check("post_rst_busy", busy, 0);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0;
        x0 = '0; y0 = '0; w = '0; h = '0; color_in = '0;
`ifdef RECT_OUTLINE_EN
        outline = 1'b0;
`endif
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        check_all_zero("reset");
        rst_n = 1'b1;

        run_cmd(10, 20, 2, 2, 8'hE0, 1'b0, 1'b0);    // basic 2x2 fill
        run_cmd(158, 118, 5, 5, 8'h1C, 1'b0, 1'b0);  // clipped on both edges
        run_cmd(30, 30, 0, 5, 8'h11, 1'b0, 1'b0);    // zero width
        run_cmd(30, 30, 5, 0, 8'h12, 1'b0, 1'b0);    // zero height
        run_cmd(200, 10, 4, 4, 8'h13, 1'b0, 1'b0);   // off-screen origin
        run_cmd(4, 7, 4, 1, 8'h3C, 1'b0, 1'b1);      // start ignored while busy
        run_cmd(0, 119, 255, 1, 8'hFF, 1'b0, 1'b0);  // bottom row, clipped width
        reset_mid_command();
        run_cmd(1, 2, 3, 2, 8'hA5, 1'b0, 1'b0);      // normal draw after reset
`ifdef RECT_OUTLINE_EN
        run_cmd(5, 5, 3, 3, 8'h77, 1'b1, 1'b0);      // 3x3 outline, interior skipped
        run_cmd(150, 100, 20, 30, 8'h66, 1'b1, 1'b0); // outline with off-screen borders
`endif

        for (int i = 0; i < 30; i++) begin
            bit ol;
            ol = 1'b0;
`ifdef RECT_OUTLINE_EN
            ol = 1'($urandom_range(0, 1));
`endif
            run_cmd(int'($urandom_range(0, 175)), int'($urandom_range(0, 130)),
                    int'($urandom_range(0, 24)), int'($urandom_range(0, 16)),
                    int'($urandom_range(0, 255)), ol, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
